// File: rtl/puf_test_pkg.sv
// Shared constants and state type for the PUF test result-memory
// writer and reader.
package puf_test_pkg;

  localparam int RESULT_BASE_ADDR = 1;
  localparam int RESULT_NUM_WORDS = 8;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_RD,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/result_mem_reader_sync_2ff.sv
// Generic 2-flop level synchronizer.
// Resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/result_mem_reader.sv
// Reads the pass-count words from result memory and streams them
// to the host as HEADER, LEN, words, checksum over valid/ready.
module result_mem_reader
  import puf_test_pkg::*;
#(
  parameter int              ADDR_WIDTH = 13,
  parameter int              DATA_WIDTH = 8,
  parameter int              BASE_ADDR  = RESULT_BASE_ADDR,
  parameter int              NUM_WORDS  = RESULT_NUM_WORDS,
  parameter int              RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] HEADER = FRAME_HEADER
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_done,
  input  logic                  host_req,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] LEN_BYTE =
    DATA_WIDTH'(NUM_WORDS);

  rd_state_t             r_state;
  rd_state_t             w_next;
  logic                  w_td_sync;
  logic                  r_td_prev;
  logic                  r_armed;
  logic [7:0]            r_idx;
  logic [1:0]            r_wcnt;
  logic [DATA_WIDTH-1:0] r_csum;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  w_hs;
  logic                  w_start;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (test_done),
    .o_q   (w_td_sync)
  );

  assign w_hs    = out_valid & out_ready;
  // host_req and a trigger in the same cycle merge into one start
  assign w_start = host_req | (w_td_sync & ~r_td_prev & r_armed);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_next = ST_HDR;
      ST_HDR:  if (w_hs) w_next = ST_LEN;
      ST_LEN:  if (w_hs) w_next = ST_RD;
      ST_RD:   w_next = ST_WAIT;
      ST_WAIT: if (r_wcnt == LAT_LAST) w_next = ST_SEND;
      ST_SEND: if (w_hs)
        w_next = (r_idx < LAST_IDX) ? ST_RD : ST_CSUM;
      ST_CSUM: if (w_hs) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_re     = 1'b0;
    mem_raddr  = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    busy       = (r_state != ST_IDLE);
    frame_done = 1'b0;
    unique case (r_state)
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = HEADER;
      end
      ST_LEN: begin
        out_valid = 1'b1;
        out_data  = LEN_BYTE;
      end
      ST_RD: begin
        mem_re    = 1'b1;
        mem_raddr = ADDR_WIDTH'(BASE_ADDR)
                  + ADDR_WIDTH'(r_idx);
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = r_hold;
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = r_csum;
      end
      ST_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_td_prev <= 1'b0;
      r_armed   <= 1'b1;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_csum    <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_next;
      r_td_prev <= w_td_sync;
      if (r_state == ST_DONE)
        r_armed <= 1'b0;
      else if (!w_td_sync)
        r_armed <= 1'b1;
      unique case (r_state)
        ST_LEN: if (w_hs) begin
          r_csum <= LEN_BYTE;
          r_idx  <= '0;
        end
        ST_RD: r_wcnt <= '0;
        ST_WAIT: begin
          r_wcnt <= r_wcnt + 2'd1;
          if (r_wcnt == LAT_LAST)
            r_hold <= mem_dout;
        end
        ST_SEND: if (w_hs) begin
          r_csum <= r_csum ^ r_hold;
          r_idx  <= r_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_mem_reader.sv
// Directed bench for result_mem_reader: frames, back-pressure,
// rearm, host_req, async reset, and 2-cycle read latency.
module tb_result_mem_reader;
  import puf_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        test_done = 1'b0;
  logic        host_req = 1'b0;
  logic        out_ready = 1'b1;
  logic        mem_re;
  logic [12:0] mem_raddr;
  logic [7:0]  mem_dout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        frame_done;

  logic        td2 = 1'b0;
  logic        host_req2 = 1'b0;
  logic        out_ready2 = 1'b1;
  logic        mem_re2;
  logic [12:0] mem_raddr2;
  logic [7:0]  mem_dout2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic        busy2;
  logic        frame_done2;

  result_mem_reader dut (
    .clk(clk), .rst_n(rst_n), .test_done(test_done),
    .host_req(host_req), .mem_re(mem_re),
    .mem_raddr(mem_raddr), .mem_dout(mem_dout),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done)
  );

  result_mem_reader #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .test_done(td2),
    .host_req(host_req2), .mem_re(mem_re2),
    .mem_raddr(mem_raddr2), .mem_dout(mem_dout2),
    .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .busy(busy2),
    .frame_done(frame_done2)
  );

  logic [7:0] mem [0:8191];
  logic [7:0] m1_d = 8'h00;
  logic [7:0] m2_d1 = 8'h00;
  logic [7:0] m2_d2 = 8'h00;

  always @(posedge clk) begin
    if (mem_re) m1_d <= mem[mem_raddr];
    if (mem_re2) m2_d1 <= mem[mem_raddr2];
    m2_d2 <= m2_d1;
  end
  assign mem_dout  = m1_d;
  assign mem_dout2 = m2_d2;

  logic [7:0]  bytes[$];
  logic [7:0]  bytes2[$];
  logic [12:0] raddrs[$];
  int frames = 0;
  int frames2 = 0;
  int stab_err = 0;
  int stalls = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(negedge clk) begin
    if (out_valid && out_ready) bytes.push_back(out_data);
    if (frame_done) frames++;
    if (mem_re) raddrs.push_back(mem_raddr);
    if (stall_prev && (!out_valid || out_data !== stall_data))
      stab_err++;
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (stall_prev) stalls++;
    if (out_valid2 && out_ready2) bytes2.push_back(out_data2);
    if (frame_done2) frames2++;
  end

  logic [7:0] exp_frame [11] = '{
    8'hA5, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
    8'h0E, 8'h0F, 8'h10, 8'h11, 8'h08
  };

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input string tag,
                             input int target,
                             input bit bp,
                             input int fstart);
    int n = 0;
    int last_n = -1;
    int stl = 0;
    while (frames < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (bp) begin
        if (bytes.size() != last_n) begin
          last_n = bytes.size();
          stl = 0;
        end
        if (out_valid && ((bytes.size() - fstart) % 3 == 2)
            && stl < 5) begin
          out_ready = 1'b0;
          stl++;
        end else begin
          out_ready = 1'b1;
        end
      end
    end
    out_ready = 1'b1;
    chk({tag, "_timeout"}, 32'(frames >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int start);
    chk({tag, "_len"}, 32'(bytes.size() - start), 32'd11);
    for (int i = 0; i < 11; i++)
      if (start + i < bytes.size())
        chk($sformatf("%s_b%0d", tag, i),
            32'(bytes[start + i]), 32'(exp_frame[i]));
  endtask

  initial begin
    int fs;
    int f0;
    int n;
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    for (int a = 1; a <= 8; a++) mem[a] = 8'(a + 9);

    cyc(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // basic frame on test_done
    fs = bytes.size();
    test_done = 1'b1;
    wait_frames("basic", 1, 1'b0, fs);
    cyc(5);
    check_frame("basic", fs);
    chk("basic_frames", 32'(frames), 32'd1);
    chk("basic_idle", 32'(busy), 32'd0);
    chk("basic_nrd", 32'(raddrs.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < raddrs.size())
        chk($sformatf("basic_addr%0d", i),
            32'(raddrs[i]), 32'(i + 1));

    // back-pressure, started by host_req
    fs = bytes.size();
    stalls = 0;
    host_req = 1'b1;
    cyc(1);
    host_req = 1'b0;
    wait_frames("bp", 2, 1'b1, fs);
    cyc(5);
    check_frame("bp", fs);
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_stalls", 32'(stalls), 32'd15);

    // test_done held high: no retrigger
    cyc(500);
    chk("hold_frames", 32'(frames), 32'd2);
    test_done = 1'b0;
    cyc(10);
    fs = bytes.size();
    test_done = 1'b1;
    wait_frames("rearm", 3, 1'b0, fs);
    cyc(50);
    check_frame("rearm", fs);
    chk("rearm_frames", 32'(frames), 32'd3);

    // host_req in idle, second pulse while busy ignored
    test_done = 1'b0;
    cyc(10);
    fs = bytes.size();
    host_req = 1'b1;
    cyc(1);
    host_req = 1'b0;
    cyc(4);
    chk("hreq_busy", 32'(busy), 32'd1);
    host_req = 1'b1;
    cyc(1);
    host_req = 1'b0;
    wait_frames("hreq", 4, 1'b0, fs);
    cyc(100);
    check_frame("hreq", fs);
    chk("hreq_frames", 32'(frames), 32'd4);

    // trigger and host_req in the same cycle
    test_done = 1'b1;
    cyc(2);
    host_req = 1'b1;
    cyc(1);
    host_req = 1'b0;
    wait_frames("both", 5, 1'b0, bytes.size());
    cyc(100);
    chk("both_frames", 32'(frames), 32'd5);

    // async reset during SEND of word 3
    test_done = 1'b0;
    cyc(10);
    fs = bytes.size();
    test_done = 1'b1;
    n = 0;
    while (!(out_valid && bytes.size() - fs == 5) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("arst_found", 32'(n < 200), 32'd1);
    chk("arst_word3", 32'(out_data), 32'h0D);
    f0 = frames;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fdone", 32'(frame_done), 32'd0);
    cyc(3);
    chk("arst_nofd", 32'(frames), 32'(f0));
    rst_n = 1'b1;
    fs = bytes.size();
    wait_frames("arst", f0 + 1, 1'b0, fs);
    cyc(50);
    check_frame("arst", fs);
    chk("arst_frames", 32'(frames), 32'(f0 + 1));

    // RD_LATENCY = 2 instance
    host_req2 = 1'b1;
    cyc(1);
    host_req2 = 1'b0;
    n = 0;
    while (frames2 < 1 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat2_timeout", 32'(frames2 >= 1), 32'd1);
    chk("lat2_len", 32'(bytes2.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < bytes2.size())
        chk($sformatf("lat2_b%0d", i),
            32'(bytes2[i]), 32'(exp_frame[i]));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/result_mem_reader.md
Name: result_mem_reader

Overview:
- Read-side counterpart to the PUF test FSM's result-memory writer.
- Once the test FSM raises test_done, reads the eight pass-count bytes from the result memory and streams them to the host as a framed byte stream over valid/ready.
- Sits between the result memory read port and the host interface. test_done comes from another clock domain.

Parameters:
- ADDR_WIDTH, 13, result memory address width.
- DATA_WIDTH, 8, result memory word / stream byte width.
- BASE_ADDR, 1, address of the first result word (test1).
- NUM_WORDS, 8, number of result words per frame (1..255).
- RD_LATENCY, 1, memory read latency in clk cycles (1 or 2).
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  single block clock.
- rst_n  in  1  asynchronous active-low reset.
- test_done  in  1  level from the test FSM; asynchronous to clk.
- host_req  in  1  one-cycle pulse; requests a re-send of the current results.
- mem_re  out  1  memory read enable.
- mem_raddr  out  ADDR_WIDTH  memory read address.
- mem_dout  in  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after mem_re.
- out_data  out  DATA_WIDTH  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  host accepts the byte when out_valid & out_ready.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: all outputs 0, mem_raddr = 0, state IDLE, synchronizer flops 0, armed = 1.
- test_done passes through a 2-flop synchronizer; a start trigger is a rising edge of the synced value while armed = 1.
- Start in IDLE on trigger, or on host_req. If both occur in the same cycle, exactly one frame is sent.
- Frame format: HEADER, NUM_WORDS, word[0..NUM_WORDS-1], checksum.
  - checksum = XOR of all bytes starting from the NUM_WORDS byte through the last word; HEADER is excluded.
- States:
  - IDLE: busy = 0.
  - HDR: out_valid = 1, out_data = HEADER; advance on handshake.
  - LEN: out_data = NUM_WORDS; advance on handshake; checksum register loaded with NUM_WORDS.
  - RD: mem_re = 1 for exactly one cycle, mem_raddr = BASE_ADDR + idx; go to WAIT.
  - WAIT: count RD_LATENCY cycles, then capture mem_dout into a holding register and go to SEND.
  - SEND: out_data = holding register, out_valid = 1; on handshake XOR the byte into the checksum and increment idx; go to RD if idx < NUM_WORDS-1, else to CSUM.
  - CSUM: out_data = checksum; on handshake go to DONE.
  - DONE: frame_done = 1 for one cycle, armed = 0; go to IDLE.
- Handshake rules:
  - out_valid never drops and out_data never changes until the handshake occurs.
  - out_ready may be held low indefinitely (back-pressure).
  - Throughput is not required to be 1 byte/cycle.
- armed returns to 1 when synced test_done = 0. A test_done that stays high therefore never retriggers.
- host_req is ignored while busy = 1.
- Address arithmetic is modulo 2^ADDR_WIDTH; BASE_ADDR + NUM_WORDS - 1 wraps.
- Deasserting rst_n mid-frame aborts immediately: outputs return to reset values and no frame_done is issued.
- test_done falling mid-frame does not abort the frame.

Decomposition:
- Shared package puf_test_pkg holds:
  - RESULT_BASE_ADDR = 1
  - RESULT_NUM_WORDS = 8
  - FRAME_HEADER = 8'hA5
  - the state enumeration typedef
- Writer and reader use the same package constants.
- One sub-module, sync_2ff (generic 2-flop level synchronizer), is instantiated for test_done.

Test Plan:
- Basic frame, ready always high. Memory preloaded with 10..17 at addresses 1..8; test_done raised. Required stream: A5, 08, 0A, 0B, 0C, 0D, 0E, 0F, 10, 11, 08 (checksum = 08 ^ 0A ^ ... ^ 11 = 08); then one frame_done pulse; mem_raddr sequence 1..8.
- Back-pressure. Same data; out_ready low for 5 cycles on every third byte. Required: identical byte sequence; out_data stable while valid and not ready; no dropped or duplicated bytes.
- Level hold / rearm. test_done held high for 500 cycles after the frame, then toggled low→high. Required: exactly two frames total; no frame while held high.
- host_req. host_req pulsed in IDLE with test_done = 0. Required: one full frame. host_req pulsed again while busy: ignored, still one frame.
- Async reset mid-frame. rst_n asserted during the SEND of word 3. Required: out_valid = 0, busy = 0 immediately, no frame_done. After release with test_done still high and armed = 1, one fresh frame starting with A5.
- RD_LATENCY = 2 with a memory model delaying data 2 cycles. Required: same byte stream as the basic-frame case.
